// File: rtl/if_fetch_pkg.sv
// Shared types and size helpers for the input-feature fetch unit.
// Build option: define IF_ZERO_PAD_EN for "same" zero padding.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_e;

`ifdef IF_ZERO_PAD_EN
    localparam int PAD_EN = 1;
`else
    localparam int PAD_EN = 0;
`endif

    function automatic int calc_out_w(int img_w, int k);
        return (PAD_EN != 0) ? img_w : img_w - k + 1;
    endfunction

    function automatic int calc_out_h(int img_h, int k);
        return (PAD_EN != 0) ? img_h : img_h - k + 1;
    endfunction

    function automatic int calc_total(int img_w, int img_h, int k);
        return calc_out_w(img_w, k) * calc_out_h(img_h, k) * k * k;
    endfunction

    function automatic int cnt_w(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/if_fetch_unit_window_counter.sv
// Nested oy/ox/ky/kx window counters walking a feature map in im2col order.
// kx is innermost; `last` flags the final tap of the final output position.
module window_counter
    import if_fetch_pkg::*;
#(
    parameter int OUT_W = 6,
    parameter int OUT_H = 6,
    parameter int K     = 3,
    parameter int OY_W  = cnt_w(OUT_H),
    parameter int OX_W  = cnt_w(OUT_W),
    parameter int KW    = cnt_w(K)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    output logic [OY_W-1:0] oy,
    output logic [OX_W-1:0] ox,
    output logic [KW-1:0]   ky,
    output logic [KW-1:0]   kx,
    output logic            last
);

    logic [OY_W-1:0] oy_q, oy_d;
    logic [OX_W-1:0] ox_q, ox_d;
    logic [KW-1:0]   ky_q, ky_d;
    logic [KW-1:0]   kx_q, kx_d;
    logic            oy_max, ox_max, ky_max, kx_max;

    assign oy_max = (oy_q == OY_W'(OUT_H - 1));
    assign ox_max = (ox_q == OX_W'(OUT_W - 1));
    assign ky_max = (ky_q == KW'(K - 1));
    assign kx_max = (kx_q == KW'(K - 1));

    always_comb begin
        oy_d = oy_q;
        ox_d = ox_q;
        ky_d = ky_q;
        kx_d = kx_q;
        if (clr) begin
            oy_d = '0;
            ox_d = '0;
            ky_d = '0;
            kx_d = '0;
        end else if (adv) begin
            // Each counter wraps and carries into the next outer one.
            kx_d = kx_max ? '0 : kx_q + 1'b1;
            if (kx_max) begin
                ky_d = ky_max ? '0 : ky_q + 1'b1;
                if (ky_max) begin
                    ox_d = ox_max ? '0 : ox_q + 1'b1;
                    if (ox_max) begin
                        oy_d = oy_max ? '0 : oy_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oy_q <= '0;
            ox_q <= '0;
            ky_q <= '0;
            kx_q <= '0;
        end else begin
            oy_q <= oy_d;
            ox_q <= ox_d;
            ky_q <= ky_d;
            kx_q <= kx_d;
        end
    end

    assign oy   = oy_q;
    assign ox   = ox_q;
    assign ky   = ky_q;
    assign kx   = kx_q;
    assign last = oy_max & ox_max & ky_max & kx_max;

endmodule

// File: rtl/if_fetch_unit.sv
// Input-feature fetch unit: streams KxK window taps of one map from SRAM.
// Build option: IF_ZERO_PAD_EN enables "same" zero padding of border taps.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read,
    input  logic              clr_if,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              if_stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    output logic              if_done
);

    localparam int OUT_W = calc_out_w(IMG_W, K);
    localparam int OUT_H = calc_out_h(IMG_H, K);
    localparam int OY_W  = cnt_w(OUT_H);
    localparam int OX_W  = cnt_w(OUT_W);
    localparam int KW    = cnt_w(K);
`ifdef IF_ZERO_PAD_EN
    localparam int P     = (K - 1) / 2;
`endif

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              vld_q, vld_d;
    logic              issue, cnt_clr, cnt_adv, last;
    logic [OY_W-1:0]   oy;
    logic [OX_W-1:0]   ox;
    logic [KW-1:0]     ky, kx;
    logic [ADDR_W-1:0] tap_addr;
    int                row_i, col_i;

    window_counter #(
        .OUT_W(OUT_W),
        .OUT_H(OUT_H),
        .K    (K)
    ) u_win (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .adv (cnt_adv),
        .oy  (oy),
        .ox  (ox),
        .ky  (ky),
        .kx  (kx),
        .last(last)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        issue   = 1'b0;
        if_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (if_read) begin
                    base_d  = base_addr;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!if_stall) begin
                    issue   = 1'b1;
                    cnt_adv = 1'b1;
                    if (last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if_done = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
        // clr_if overrides everything, including a same-cycle if_read.
        if (clr_if) begin
            state_d = ST_IDLE;
            base_d  = base_q;
            cnt_clr = 1'b1;
            cnt_adv = 1'b0;
            issue   = 1'b0;
        end
    end

`ifdef IF_ZERO_PAD_EN
    logic oob, pad_q, pad_d;

    always_comb begin
        row_i    = int'(oy) + int'(ky) - P;
        col_i    = int'(ox) + int'(kx) - P;
        oob      = (row_i < 0) || (row_i >= IMG_H) || (col_i < 0) || (col_i >= IMG_W);
        tap_addr = base_q + ADDR_W'(row_i * IMG_W + col_i);
        // Out-of-bounds taps still produce a (zero) beat but never touch SRAM.
        mem_rd_en = issue && !oob;
        mem_addr  = mem_rd_en ? tap_addr : '0;
        vld_d     = issue;
        pad_d     = issue && oob;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pad_q <= 1'b0;
        else     pad_q <= pad_d;
    end

    assign if_data = (vld_q && !pad_q) ? mem_rd_data : '0;
`else
    always_comb begin
        row_i     = int'(oy) + int'(ky);
        col_i     = int'(ox) + int'(kx);
        tap_addr  = base_q + ADDR_W'(row_i * IMG_W + col_i);
        mem_rd_en = issue;
        mem_addr  = mem_rd_en ? tap_addr : '0;
        vld_d     = issue;
    end

    assign if_data = vld_q ? mem_rd_data : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            vld_q   <= vld_d;
        end
    end

    assign if_valid = vld_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a behavioural SRAM and an im2col address model.
// Expectations follow IF_ZERO_PAD_EN when the bench is built with it.
module tb_if_fetch_unit;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int K     = 3;
`ifdef IF_ZERO_PAD_EN
    localparam int PAD     = 1;
    localparam int EXP_ISS = 484;
    localparam logic [15:0] BASE_A = 16'h0000;
`else
    localparam int PAD     = 0;
    localparam int EXP_ISS = 324;
    localparam logic [15:0] BASE_A = 16'h0100;
`endif
    localparam int P     = (PAD != 0) ? (K - 1) / 2 : 0;
    localparam int OW    = (PAD != 0) ? IMG_W : IMG_W - K + 1;
    localparam int OH    = (PAD != 0) ? IMG_H : IMG_H - K + 1;
    localparam int TOTAL = OW * OH * K * K;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_read = 1'b0;
    logic        clr_if = 1'b0;
    logic        if_stall = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic [7:0]  if_data;
    logic        if_valid;
    logic        if_done;

    if_fetch_unit #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(16), .DATA_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_read    (if_read),
        .clr_if     (clr_if),
        .base_addr  (base_addr),
        .if_stall   (if_stall),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .if_data    (if_data),
        .if_valid   (if_valid),
        .if_done    (if_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sram_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram_val(mem_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] iss_q[$];
    logic [7:0]  dat_q[$];
    int          dat_cyc[$];
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) iss_q.push_back(mem_addr);
            if (if_valid) begin
                dat_q.push_back(if_data);
                dat_cyc.push_back(cyc);
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void ref_tap(input logic [15:0] base, input int idx,
                                    output logic [15:0] addr, output bit oob);
        int oy, ox, ky, kx, r, row, col;
        oy   = idx / (OW * K * K);
        r    = idx % (OW * K * K);
        ox   = r / (K * K);
        r    = r % (K * K);
        ky   = r / K;
        kx   = r % K;
        row  = oy + ky - P;
        col  = ox + kx - P;
        oob  = (row < 0) || (row >= IMG_H) || (col < 0) || (col >= IMG_W);
        addr = base + 16'(row * IMG_W + col);
    endfunction

    function automatic longint get_iss(input int i);
        if (i < iss_q.size()) return longint'(iss_q[i]);
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_q.delete();
        dat_q.delete();
        dat_cyc.delete();
    endtask

    task automatic start(input logic [15:0] b);
        tick(1);
        if_read   = 1'b1;
        base_addr = b;
        tick(1);
        if_read   = 1'b0;
    endtask

    task automatic pulse_clr();
        tick(1);
        clr_if = 1'b1;
        tick(1);
        clr_if = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            sample();
            if (if_done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic check_run(input string tag, input logic [15:0] base, input bit no_gap);
        int          bad_a = 0;
        int          bad_d = 0;
        int          j = 0;
        logic [15:0] a;
        logic [7:0]  exp_d;
        bit          oob;
        check({tag, "_iss_cnt"}, iss_q.size(), EXP_ISS);
        check({tag, "_beat_cnt"}, dat_q.size(), TOTAL);
        for (int idx = 0; idx < TOTAL; idx++) begin
            ref_tap(base, idx, a, oob);
            if (!oob) begin
                if (j >= iss_q.size() || iss_q[j] !== a) bad_a++;
                j++;
            end
            if (idx < dat_q.size()) begin
                exp_d = oob ? 8'h00 : sram_val(a);
                if (dat_q[idx] !== exp_d) bad_d++;
            end
        end
        check({tag, "_addr_seq_errs"}, bad_a, 0);
        check({tag, "_data_seq_errs"}, bad_d, 0);
        if (dat_q.size() > 0) begin
            check({tag, "_done_after_last_beat"}, done_cyc - dat_cyc[dat_q.size()-1], 1);
            if (no_gap) check({tag, "_beat_span"}, dat_cyc[dat_q.size()-1] - dat_cyc[0], TOTAL - 1);
        end
    endtask

    typedef struct {
        logic [15:0] base;
        int          iss_idx;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          n0, d0;
        bit          hit;
`ifdef IF_ZERO_PAD_EN
        tbl[0] = '{16'h0000, 0,   16'h0000};
        tbl[1] = '{16'h0000, 1,   16'h0001};
        tbl[2] = '{16'h0000, 2,   16'h0008};
        tbl[3] = '{16'h0000, 3,   16'h0009};
        tbl[4] = '{16'h0000, 4,   16'h0000};
        tbl[5] = '{16'h0000, 5,   16'h0001};
        tbl[6] = '{16'h0000, 6,   16'h0002};
        tbl[7] = '{16'h0000, 9,   16'h000A};
        tbl[8] = '{16'h0000, 482, 16'h003E};
        tbl[9] = '{16'h0000, 483, 16'h003F};
`else
        tbl[0] = '{16'h0100, 0,   16'h0100};
        tbl[1] = '{16'h0100, 1,   16'h0101};
        tbl[2] = '{16'h0100, 2,   16'h0102};
        tbl[3] = '{16'h0100, 3,   16'h0108};
        tbl[4] = '{16'h0100, 4,   16'h0109};
        tbl[5] = '{16'h0100, 5,   16'h010A};
        tbl[6] = '{16'h0100, 6,   16'h0110};
        tbl[7] = '{16'h0100, 9,   16'h0101};
        tbl[8] = '{16'h0100, 54,  16'h0108};
        tbl[9] = '{16'h0100, 323, 16'h013F};
`endif

        // Reset state
        tick(2);
        sample();
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_data", if_data, 0);
        check("rst_if_done", if_done, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Full run from the table base, no stall
        clear_logs();
        start(tbl[0].base);
        wait_done("runA", 2000);
        check_run("runA", tbl[0].base, 1'b1);
        for (int i = 0; i < 10; i++)
            check($sformatf("tbl%0d_addr", i), get_iss(tbl[i].iss_idx), longint'(tbl[i].exp_addr));

        // if_done holds; if_read in DONE ignored; clr_if returns to IDLE
        tick(5);
        sample();
        check("done_hold", if_done, 1);
        n0 = iss_q.size();
        start(16'h0300);
        tick(3);
        sample();
        check("read_in_done_iss", iss_q.size(), n0);
        check("read_in_done_still_done", if_done, 1);
        pulse_clr();
        sample();
        check("clr_done_low", if_done, 0);
        check("clr_rd_en_low", mem_rd_en, 0);
        check("clr_valid_low", if_valid, 0);
        tick(3);
        sample();
        check("idle_after_clr_iss", iss_q.size(), n0);

        // if_read together with clr_if in IDLE: stays idle
        tick(1);
        if_read   = 1'b1;
        clr_if    = 1'b1;
        base_addr = 16'h0500;
        tick(1);
        if_read   = 1'b0;
        clr_if    = 1'b0;
        tick(4);
        sample();
        check("read_clr_idle_iss", iss_q.size(), n0);
        check("read_clr_idle_done", if_done, 0);

        // Five-cycle stall mid-fetch
        clear_logs();
        start(BASE_A);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            sample();
            if (iss_q.size() >= 50) hit = 1'b1;
        end
        if (!hit) check("stall_reach_timeout", 0, 1);
        @(posedge clk);
        #2;
        if_stall = 1'b1;
        n0 = iss_q.size();
        d0 = dat_q.size();
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("stall_rd_en_c%0d", i), mem_rd_en, 0);
            @(posedge clk);
            #2;
        end
        if_stall = 1'b0;
        check("stall_no_issue", iss_q.size(), n0);
        check("stall_pending_beat", dat_q.size(), d0 + 1);
        wait_done("stall", 2000);
        check_run("stall", BASE_A, 1'b0);
        pulse_clr();

        // clr_if at beat 100, then restart at 0x0200
        clear_logs();
        start(BASE_A);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            sample();
            if (dat_q.size() >= 100) hit = 1'b1;
        end
        if (!hit) check("clr100_reach_timeout", 0, 1);
        @(posedge clk);
        #2;
        clr_if = 1'b1;
        tick(1);
        clr_if = 1'b0;
        sample();
        check("clr100_rd_en", mem_rd_en, 0);
        check("clr100_valid", if_valid, 0);
        check("clr100_done", if_done, 0);
        n0 = iss_q.size();
        tick(5);
        sample();
        check("clr100_no_issue", iss_q.size(), n0);
        clear_logs();
        start(16'h0200);
        wait_done("run200", 2000);
        check("restart_first_addr", get_iss(0), 16'h0200);
        check_run("run200", 16'h0200, 1'b1);
        pulse_clr();

        // Address wrap from base 0xFFFE
        clear_logs();
        start(16'hFFFE);
        wait_done("wrap", 2000);
        check("wrap_iss0", get_iss(0), 16'hFFFE);
        check("wrap_iss1", get_iss(1), 16'hFFFF);
`ifdef IF_ZERO_PAD_EN
        check("wrap_iss2", get_iss(2), 16'h0006);
        check("wrap_iss3", get_iss(3), 16'h0007);
`else
        check("wrap_iss2", get_iss(2), 16'h0000);
        check("wrap_iss3", get_iss(3), 16'h0006);
`endif
        check_run("wrap", 16'hFFFE, 1'b1);
        pulse_clr();

        // Asynchronous reset mid-fetch
        clear_logs();
        start(BASE_A);
        tick(20);
        rst = 1'b1;
        #1;
        check("async_rst_rd_en", mem_rd_en, 0);
        check("async_rst_valid", if_valid, 0);
        check("async_rst_addr", mem_addr, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        n0 = iss_q.size();
        tick(4);
        sample();
        check("post_rst_idle_iss", iss_q.size(), n0);
        check("post_rst_done", if_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
